seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Runtime-programmable serial bit-pattern detector, Moore style (registered, one-cycle match pulse).
//  - Pattern length up to MAX_LEN; overlapping or non-overlapping mode, selected at runtime.
//  - Input qualified by din_valid; saturating match counter.
//  - Generalises the fixed 1001 detectors; reset defaults reproduce a 1001 non-overlapping detector.
// PARAMETERS
//  MAX_LEN      8          maximum pattern length in bits (>=1)
//  LEN_W        4          width of pat_len; must hold MAX_LEN
//  CNT_W        8          match_count width
//  DEF_PATTERN  8'b1001    pattern value after reset, right-aligned
//  DEF_LEN      4          pattern length after reset
//  DEF_OVERLAP  0          overlap mode after reset
// PORTS
//  clk          in   1        clock; all logic is on the rising edge
//  reset        in   1        synchronous, active-high reset
//  din          in   1        serial data bit
//  din_valid    in   1        din is sampled only when this is 1
//  cfg_load     in   1        1-cycle strobe; latches pattern, pat_len and overlap
//  pattern      in   MAX_LEN  pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last
//  pat_len      in   LEN_W    pattern length, 1..MAX_LEN
//  overlap      in   1        1 = overlapping detection, 0 = non-overlapping
//  dout         out  1        match pulse, one cycle wide
//  match_count  out  CNT_W    number of matches, saturating
//  cur_len      out  LEN_W    active (latched) pattern length
// BEHAVIOUR
//  Reset (synchronous, priority over everything):
//   - dout=0, match_count=0, history=0, fill=0.
//   - Config regs load DEF_PATTERN, DEF_LEN, DEF_OVERLAP; cur_len=DEF_LEN.
//  State:
//   - hist: MAX_LEN-bit shift register of accepted bits, newest in bit 0.
//   - fill: count of accepted bits since last clear, saturating at MAX_LEN.
//  Accept cycle (din_valid=1, cfg_load=0, reset=0):
//   - nh = {hist[MAX_LEN-2:0], din}; nf = min(fill+1, MAX_LEN).
//   - hit = (nf >= L) && (nh[L-1:0] == pat_q[L-1:0]), where L is the latched length.
//   - hist <= nh; dout <= hit.
//   - If hit and overlap_q=0: fill <= 0, so the next match needs L fresh bits.
//   - Otherwise fill <= nf.
//   - If hit: match_count <= match_count+1, saturating at all-ones.
//  Latency and hold:
//   - dout rises at the same edge that samples the last pattern bit.
//   - dout is high for exactly one cycle per match.
//   - Cycle with din_valid=0: hist, fill and match_count hold; dout <= 0.
//  Configuration (cfg_load=1):
//   - Latch pattern, pat_len and overlap; clear hist and fill; dout <= 0.
//   - match_count is not cleared.
//   - If din_valid=1 in the same cycle, that din bit is discarded.
//  Length edge cases:
//   - pat_len=0 latched: detector disabled, dout stays 0.
//   - pat_len > MAX_LEN: clamped to MAX_LEN.
//  Mode change takes effect only through cfg_load; the live overlap pin is ignored otherwise.
//  Reset mid-pattern: partial match is discarded, and the config returns to the defaults.
// TESTING
//  T1 defaults (1001, non-overlap), accept 1,0,0,1,0,0,1 back-to-back
//     -> dout pulses only at the 4th bit; match_count=1.
//  T2 cfg_load 1001 with overlap=1, same stream
//     -> dout pulses at the 4th and 7th bits; match_count=2.
//  T3 pattern 1001, din_valid toggled 0 between every bit
//     -> same results as T1/T2; dout never high during valid=0 cycles.
//  T4 pat_len=1, pattern=1, non-overlap, stream 1,1,0,1 -> 3 pulses.
//     pat_len=8, pattern 8'hA5 -> pulse only after all 8 bits are accepted.
//  T5 CNT_W=2, overlap, pattern 1, 5 ones -> match_count goes 1,2,3,3,3.
//     cfg_load then leaves the count at 3.
//  T6 sequence cases:
//     - After accepting 1,0,0: reset, then send 1 -> no pulse; cur_len=4.
//     - After 1,0,0: cfg_load with din_valid=1 -> that bit is dropped; no pulse until 4 new bits.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Purpose : bundles the data, configuration and result signals of seq_detector_param.
// Latency : none, wiring only.
// Backpressure: none; din_valid qualifies din, and the sink never stalls.
// Signals : din/din_valid serial input, cfg_load/pattern/pat_len/overlap configuration,
//           dout/match_count/cur_len results. master = stimulus side, slave = detector.
interface seq_detector_param_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               din;
   logic               din_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap;
   logic               dout;
   logic [CNT_W-1:0]   match_count;
   logic [LEN_W-1:0]   cur_len;

   modport master (
      output din, din_valid, cfg_load, pattern, pat_len, overlap,
      input  dout, match_count, cur_len
   );

   modport slave (
      input  din, din_valid, cfg_load, pattern, pat_len, overlap,
      output dout, match_count, cur_len
   );
endinterface

// File: rtl/seq_detector_param.sv
// Purpose : runtime-programmable serial pattern detector, overlapping or non-overlapping.
// Latency : dout is registered and rises on the edge that samples the last pattern bit.
// Backpressure: none; bits are taken only when din_valid=1, idle cycles hold all state.
// Ports   : clk, reset (synchronous, active high), bus (slave side of seq_detector_param_if).
//           The pattern is right-aligned: pattern[len-1] is the first bit, pattern[0] the last.
module seq_detector_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1001),
   parameter int                 DEF_LEN     = 4,
   parameter bit                 DEF_OVERLAP = 1'b0
) (
   input logic                clk,
   input logic                reset,
   seq_detector_param_if.slave bus
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ov_q;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic               dout_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [MAX_LEN-1:0] nh;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   nf;
   logic [LEN_W-1:0]   len_in;
   logic               hit;

   always_comb begin
      len_in = (bus.pat_len > MAX_L) ? MAX_L : bus.pat_len;
      // shift in the new bit; the cast drops the oldest bit off the top
      nh     = MAX_LEN'({hist, bus.din});
      nf     = (fill >= MAX_L) ? MAX_L : fill + LEN_W'(1);
      mask   = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
      // fill guards against matching on stale or cleared history;
      // a zero length never matches, otherwise an empty mask would match every bit
      hit    = (len_q != '0) && (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q  <= DEF_PATTERN;
         len_q  <= LEN_W'(DEF_LEN);
         ov_q   <= DEF_OVERLAP;
         hist   <= '0;
         fill   <= '0;
         dout_q <= 1'b0;
         cnt_q  <= '0;
      end else if (bus.cfg_load) begin
         // a din bit arriving with cfg_load is deliberately discarded
         pat_q  <= bus.pattern;
         len_q  <= len_in;
         ov_q   <= bus.overlap;
         hist   <= '0;
         fill   <= '0;
         dout_q <= 1'b0;
      end else if (bus.din_valid) begin
         hist   <= nh;
         dout_q <= hit;
         // non-overlapping: the next match must be built from fresh bits only
         fill   <= (hit && !ov_q) ? '0 : nf;
         if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         dout_q <= 1'b0;
      end
   end

   assign bus.dout        = dout_q;
   assign bus.match_count = cnt_q;
   assign bus.cur_len     = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Purpose : scoreboard bench for seq_detector_param; drivers queue expected results,
//           monitors pop and compare them one cycle later.
// Latency : one expected record per driven cycle, compared #1 after the sampling edge.
// Backpressure: none; the drivers never wait on the DUT.
module tb_seq_detector_param;

   typedef struct {
      bit d;
      int cnt;
      int len;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) ifa ();
   seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) ifb ();

   seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ifa)
   );

   seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifb)
   );

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;
   int   ea_cnt = 0;
   int   ea_len = 4;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(posedge clk) begin
      #1;
      if (qa.size() != 0) begin
         exp_t e;
         e = qa.pop_front();
         chk("a_dout", int'(ifa.dout), int'(e.d));
         chk("a_match_count", int'(ifa.match_count), e.cnt);
         chk("a_cur_len", int'(ifa.cur_len), e.len);
      end
   end

   always @(posedge clk) begin
      #1;
      if (qb.size() != 0) begin
         exp_t e;
         e = qb.pop_front();
         chk("b_dout", int'(ifb.dout), int'(e.d));
         chk("b_match_count", int'(ifb.match_count), e.cnt);
         chk("b_cur_len", int'(ifb.cur_len), e.len);
      end
   end

   // ---------------- drivers for DUT A ----------------
   task automatic drive_a(input bit rst, input bit cfg, input bit vld, input bit d,
                          input logic [7:0] pat, input logic [3:0] len, input bit ov,
                          input bit exp_d);
      exp_t e;
      @(negedge clk);
      rst_a         = rst;
      ifa.cfg_load  = cfg;
      ifa.din_valid = vld;
      ifa.din       = d;
      ifa.pattern   = pat;
      ifa.pat_len   = len;
      ifa.overlap   = ov;
      if (exp_d) ea_cnt++;
      e.d   = exp_d;
      e.cnt = ea_cnt;
      e.len = ea_len;
      qa.push_back(e);
   endtask

   task automatic reset_a();
      ea_cnt = 0;
      ea_len = 4;
      drive_a(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);
   endtask

   task automatic cfg_a(input logic [7:0] pat, input logic [3:0] len, input bit ov,
                        input bit vld, input bit d, input int exp_len);
      ea_len = exp_len;
      drive_a(1'b0, 1'b1, vld, d, pat, len, ov, 1'b0);
   endtask

   // bits[n-1] is sent first; pulses[i] is the expected dout for bits[i]
   task automatic seq_a(input logic [15:0] bits, input int n, input logic [15:0] pulses,
                        input bit ov_pin, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         drive_a(1'b0, 1'b0, 1'b1, bits[i], 8'hFF, 4'd1, ov_pin, pulses[i]);
         if (gaps) drive_a(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd1, ov_pin, 1'b0);
      end
   endtask

   // ---------------- driver for DUT B ----------------
   task automatic drive_b(input bit rst, input bit cfg, input bit vld, input bit d,
                          input bit exp_d, input int exp_cnt, input int exp_len);
      exp_t e;
      @(negedge clk);
      rst_b         = rst;
      ifb.cfg_load  = cfg;
      ifb.din_valid = vld;
      ifb.din       = d;
      ifb.pattern   = 8'h01;
      ifb.pat_len   = 4'd1;
      ifb.overlap   = 1'b1;
      e.d   = exp_d;
      e.cnt = exp_cnt;
      e.len = exp_len;
      qb.push_back(e);
   endtask

   initial begin
      ifa.cfg_load = 1'b0; ifa.din_valid = 1'b0; ifa.din = 1'b0;
      ifa.pattern  = '0;   ifa.pat_len   = '0;   ifa.overlap = 1'b0;
      ifb.cfg_load = 1'b0; ifb.din_valid = 1'b0; ifb.din = 1'b0;
      ifb.pattern  = '0;   ifb.pat_len   = '0;   ifb.overlap = 1'b0;

      // reset state: defaults 1001, length 4, count 0
      reset_a();
      reset_a();

      // T1: defaults, non-overlap
      seq_a(16'b1001001, 7, 16'b0001000, 1'b0, 1'b0);

      // T2: overlap enabled through cfg_load
      cfg_a(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0, 4);
      seq_a(16'b1001001, 7, 16'b0001001, 1'b0, 1'b0);

      // T3: idle cycles between bits (din=1 while idle), live overlap pin toggled opposite
      cfg_a(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0, 4);
      seq_a(16'b1001001, 7, 16'b0001001, 1'b0, 1'b1);
      cfg_a(8'b1001, 4'd4, 1'b0, 1'b0, 1'b0, 4);
      seq_a(16'b1001001, 7, 16'b0001000, 1'b1, 1'b1);

      // T4: single-bit pattern, non-overlap
      cfg_a(8'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1);
      seq_a(16'b1101, 4, 16'b1101, 1'b1, 1'b0);
      // full-width pattern A5
      cfg_a(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 8);
      seq_a(16'b10100101, 8, 16'b00000001, 1'b0, 1'b0);
      // length above MAX_LEN clamps to 8
      cfg_a(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0, 8);
      seq_a(16'b10100101, 8, 16'b00000001, 1'b0, 1'b0);
      // length 0 disables detection even for an all-zero pattern
      cfg_a(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 0);
      seq_a(16'b000, 3, 16'b000, 1'b1, 1'b0);

      // T6a: partial match then reset; config returns to 1001/4/non-overlap
      cfg_a(8'b01001, 4'd5, 1'b1, 1'b0, 1'b0, 5);
      seq_a(16'b100, 3, 16'b000, 1'b0, 1'b0);
      reset_a();
      seq_a(16'b1, 1, 16'b0, 1'b0, 1'b0);
      seq_a(16'b001, 3, 16'b001, 1'b1, 1'b0);
      seq_a(16'b001, 3, 16'b000, 1'b1, 1'b0);

      // T6b: cfg_load with a valid din=1 drops that bit and clears history
      seq_a(16'b100, 3, 16'b000, 1'b0, 1'b0);
      cfg_a(8'b1001, 4'd4, 1'b0, 1'b1, 1'b1, 4);
      seq_a(16'b1001, 4, 16'b0001, 1'b0, 1'b0);

      // T5: 2-bit saturating counter, overlap, pattern 1
      drive_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4);
      drive_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
      drive_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1);
      drive_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1);
      drive_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1);
      drive_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1);
      drive_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1);
      drive_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1);
      drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1);

      @(negedge clk);
      ifa.din_valid = 1'b0; ifa.cfg_load = 1'b0;
      ifb.din_valid = 1'b0; ifb.cfg_load = 1'b0;
      for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) begin
         @(negedge clk);
      end
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
